seq_mult_unit: RTL and testbench
================================

// Module: seq_mult_unit
// PURPOSE
//   Multi-cycle shift-and-add multiplier for the KgpRisc ALU, one add per clock.
//   Consumes the ripple-carry adder datapath: each cycle's partial-sum add goes
//   through a WIDTH-bit ripple adder built from FullAdder cells.
//   Sits beside the single-cycle ALU; the control unit stalls on busy until done.
// PARAMETERS
//   WIDTH  32  operand width in bits; product is 2*WIDTH bits
// PORTS
//   clk        in   1        single clock, rising-edge
//   rst        in   1        asynchronous, active-high reset
//   start      in   1        request: sample a/b/is_signed this cycle (IDLE only)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        two's-complement operands (honoured only with MULT_SIGNED_EN)
//   busy       out  1        high from the cycle after start until done
//   done       out  1        one-cycle pulse; product valid from this cycle
//   product    out  2*WIDTH  result; held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, product=0, internal regs=0.
//     Reset mid-operation aborts immediately; there is no partial result.
//   FSM: IDLE -> RUN -> (NEG) -> DONE -> IDLE.
//     IDLE: start=1 latches mcand=a, P={WIDTH'0,b}, cnt=0, carry=0; goes to RUN.
//     RUN, each cycle:
//       sum{c,s} = P[2W-1:W] + (P[0] ? mcand : 0), computed by the ripple adder.
//       {carry,P} <= {1'b0, c, s, P[W-1:1]}; cnt++.
//       Leaves after exactly WIDTH cycles; there is no early exit on zero operands.
//     NEG (signed build, signed op only): P <= ~P + 1 when result sign must flip.
//     DONE: product <= P, done=1 for one cycle, busy=0; goes to IDLE.
//   Latency: start sampled at edge 0; done is high in cycle WIDTH+1 (unsigned),
//     and in cycle WIDTH+2 for signed ops.
//   start while busy or in DONE: ignored; no queuing, no effect on the running op.
//   start in the same cycle as done: ignored; it must be re-issued in IDLE.
//   Width rules: adder is WIDTH bits with carry-out; the carry feeds bit 2W-1
//     on the shift. Product is exact and never overflows 2*WIDTH bits.
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//     - is_signed=1 takes magnitudes of a and b at load.
//     - Records neg = a[W-1]^b[W-1] and inserts NEG state, which two's-complements P if neg.
//     - is_signed=0 behaves as unsigned, with no NEG cycle.
//   MULT_SIGNED_EN undefined: is_signed ignored; all ops unsigned; NEG state
//     and its logic absent.
// STRUCTURE
//   Shared package (kgp_alu_pkg): FSM state encodings (IDLE/RUN/NEG/DONE) and
//     the default WIDTH constant.
//   Sub-module: ripple_adder_w (WIDTH-bit chain of FullAdder; inputs x, y, cin;
//     outputs s, cout). One instance is used for the partial-sum add.
//     The NEG increment uses a plain +1.
// TESTING (WIDTH=32)
//   - start, a=3, b=5 -> done in cycle 33, product=64'h0000_0000_0000_000F; busy 1..32.
//   - a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001
//     (exercises adder carry-out into the top bit).
//   - a=0, b=7 -> product=0, still 33-cycle latency.
//   - Second start at cycle 10 with a=9, b=9 during 3*5 -> ignored, product=15.
//   - rst pulsed at cycle 12 of an op -> busy=0, done=0, product=0 immediately.
//     A new start afterwards runs normally.
//   - MULT_SIGNED_EN, is_signed=1, a=-3 (32'hFFFF_FFFD), b=5
//     -> done in cycle 34, product=64'hFFFF_FFFF_FFFF_FFF1.
//     Without the macro, the same inputs -> product=64'h0000_0004_FFFF_FFF1 in cycle 33.

Source files
------------

// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KgpRisc ALU multi-cycle units.
//   state_e    : sequencer states of the shift-and-add multiplier
//   KGP_WIDTH  : default datapath width
package kgp_alu_pkg;

    localparam int unsigned KGP_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_NEG,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seq_mult_unit_adder.sv
// WIDTH-bit ripple-carry adder built from FullAdder cells.
// Ports:
//   FullAdder     : a, b, cin -> s, cout (single bit)
//   ripple_adder_w: x, y (WIDTH), cin -> s (WIDTH), cout
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder_w #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        FullAdder u_fa (
            .a   (x[i]),
            .b   (y[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-and-add multiplier, one ripple add per clock.
// Ports:
//   clk, rst (async, active-high)
//   start, a, b, is_signed : request and operands, sampled in IDLE only
//   busy                   : high from the cycle after start until done
//   done                   : one-cycle pulse, product valid from that cycle
//   product                : 2*WIDTH result, held until the next result
// Configuration: define MULT_SIGNED_EN to honour is_signed (magnitude
// multiply followed by a conditional two's-complement NEG cycle).
module seq_mult_unit
    import kgp_alu_pkg::*;
#(
    parameter int unsigned WIDTH = KGP_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum_s;
    logic                 sum_c;
    logic [2*WIDTH-1:0]   p_run_d;
    logic [WIDTH-1:0]     a_ld;
    logic [WIDTH-1:0]     b_ld;

    assign addend = p_q[0] ? mcand_q : '0;

    ripple_adder_w #(.WIDTH(WIDTH)) u_add (
        .x   (p_q[2*WIDTH-1:WIDTH]),
        .y   (addend),
        .cin (1'b0),
        .s   (sum_s),
        .cout(sum_c)
    );

    // Adder carry-out lands in the top product bit as the register shifts.
    assign p_run_d = {sum_c, sum_s, p_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic                 neg_q;
    logic                 sgn_q;
    logic [2*WIDTH-1:0]   p_neg_d;

    always_comb begin
        a_ld = a;
        b_ld = b;
        if (is_signed) begin
            if (a[WIDTH-1]) a_ld = ~a + 1'b1;
            if (b[WIDTH-1]) b_ld = ~b + 1'b1;
        end
    end

    assign p_neg_d = neg_q ? (~p_q + 1'b1) : p_q;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    always_comb begin
        a_ld = a;
        b_ld = b;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q <= a_ld;
                        p_q     <= {{WIDTH{1'b0}}, b_ld};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifdef MULT_SIGNED_EN
                        sgn_q   <= is_signed;
                        neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                    end
                end
                ST_RUN: begin
                    p_q   <= p_run_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
`ifdef MULT_SIGNED_EN
                        if (sgn_q) begin
                            state_q <= ST_NEG;
                        end else begin
                            product_q <= p_run_d;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_DONE;
                        end
`else
                        product_q <= p_run_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                ST_NEG: begin
                    p_q       <= p_neg_d;
                    product_q <= p_neg_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit (WIDTH=32). Honours MULT_SIGNED_EN
// the same way the design does so one file serves both builds.
module tb_seq_mult_unit;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    seq_mult_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        if (sgn && SIGNED_BUILD)
            return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic int model_lat(input logic sgn);
        return (sgn && SIGNED_BUILD) ? 34 : 33;
    endfunction

    // Launches one op, pushes its expectation, and follows it to done.
    // inj_cyc > 0 drives a competing start (9*9) in that busy cycle.
    // restart_at_done drives start during the done cycle; it must be ignored.
    task automatic do_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                         input logic sgn, input logic [63:0] exp, input int lat,
                         input int inj_cyc, input bit restart_at_done);
        int          cyc;
        bit          got;
        bit          busy_ok;
        logic [63:0] e;
        int          l;
        @(negedge clk);
        a = xa; b = xb; is_signed = sgn; start = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (cyc == inj_cyc) begin
                    a = 32'd9; b = 32'd9; start = 1'b1;
                end
            end
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check({name, " done seen"}, {63'd0, got}, 64'd1);
        check({name, " busy while running"}, {63'd0, busy_ok}, 64'd1);
        if (got) begin
            check({name, " latency"}, 64'(cyc), 64'(l));
            check({name, " product"}, product, e);
            check({name, " busy low at done"}, {63'd0, busy}, 64'd0);
            if (restart_at_done) begin
                a = 32'd2; b = 32'd2; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check({name, " done one pulse"}, {63'd0, done}, 64'd0);
            check({name, " product held"}, product, e);
            if (restart_at_done) begin
                check({name, " start at done ignored"}, {63'd0, busy}, 64'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0, 32'd7, 1'b0, 64'd0};
        vecs[3] = '{32'hFFFF_FFFD, 32'd5, 1'b1,
                    SIGNED_BUILD ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1,
                    SIGNED_BUILD ? 64'h4000_0000_0000_0000 : 64'h4000_0000_0000_0000};
        vecs[5] = '{32'h1234_5678, 32'h0000_0001, 1'b0, 64'h0000_0000_1234_5678};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset product", product, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                  vecs[i].exp, model_lat(vecs[i].sgn), 0, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = i[0];
            do_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), model_lat(rs), 0, 1'b0);
        end

        // Competing start mid-operation and start coincident with done
        do_op("ignore_start", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 33, 10, 1'b1);

        // Reset in the middle of an op aborts immediately
        @(negedge clk);
        a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid-op reset busy", {63'd0, busy}, 64'd0);
        check("mid-op reset done", {63'd0, done}, 64'd0);
        check("mid-op reset product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-reset idle", {63'd0, busy | done}, 64'd0);
        do_op("after_reset", 32'd11, 32'd13, 1'b0, 64'd143, 33, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
